// File: rtl/sc_game_pkg.sv
// rtl/sc_game_pkg.sv - game state encoding shared by the game timer and the row state machine
package sc_game_pkg;

    localparam int GAME_STATE_W = 2;

    typedef enum logic [GAME_STATE_W-1:0] {
        GAME_IDLE  = 2'd0,
        GAME_RUN   = 2'd1,
        GAME_PAUSE = 2'd2,
        GAME_END   = 2'd3
    } game_state_e;

endpackage

// File: rtl/sc_gametimer_btnsync.sv
// rtl/sc_gametimer_btnsync.sv - 2-FF synchronizer and falling-edge pulse for an active-low button
module sc_gametimer_btnsync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    // Reset to 1 so a button released at reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            sync2_d <= 1'b1;
        end else begin
            sync1   <= btn_n;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign fall = sync2_d & ~sync2;

endmodule

// File: rtl/sc_gametimer.sv
// rtl/sc_gametimer.sv - game run/stop FSM, tick prescaler and elapsed-time bus; pause via SC_GAMETIMER_PAUSE_EN
module sc_gametimer
    import sc_game_pkg::*;
#(
    parameter int TICK_DIV   = 25000000,
    parameter int TIME_WIDTH = 8,
    parameter int TIME_LIMIT = 60
) (
    input  logic                    SC_GAMETIMER_CLOCK_50,
    input  logic                    SC_GAMETIMER_RESET_InLow,
    input  logic                    SC_GAMETIMER_START_InLow,
    input  logic                    SC_GAMETIMER_CLEAR_InHigh,
`ifdef SC_GAMETIMER_PAUSE_EN
    input  logic                    SC_GAMETIMER_PAUSE_InLow,
`endif
    output logic [TIME_WIDTH-1:0]   SC_GAMETIMER_TIME_OutBUS,
    output logic                    SC_GAMETIMER_TICK_OutHigh,
    output logic [GAME_STATE_W-1:0] SC_GAMETIMER_STATE_OutBUS,
    output logic                    SC_GAMETIMER_DONE_OutHigh
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [TIME_WIDTH-1:0] TIME_LAST  = TIME_WIDTH'(TIME_LIMIT - 1);

    logic clk;
    logic rst_n;
    assign clk   = SC_GAMETIMER_CLOCK_50;
    assign rst_n = SC_GAMETIMER_RESET_InLow;

    game_state_e           state_q;
    game_state_e           state_d;
    logic [PRESC_W-1:0]    presc_q;
    logic [TIME_WIDTH-1:0] time_q;
    logic                  tick_q;
    logic                  start_evt;
    logic                  terminal;

    sc_gametimer_btnsync u_start_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (SC_GAMETIMER_START_InLow),
        .fall  (start_evt)
    );

`ifdef SC_GAMETIMER_PAUSE_EN
    logic pause_evt;

    sc_gametimer_btnsync u_pause_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (SC_GAMETIMER_PAUSE_InLow),
        .fall  (pause_evt)
    );
`endif

    assign terminal = (presc_q == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GAME_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The limit check wins over pause so the final tick always lands in END.
    always_comb begin
        state_d = state_q;
        if (SC_GAMETIMER_CLEAR_InHigh) begin
            state_d = GAME_IDLE;
        end else begin
            case (state_q)
                GAME_IDLE: if (start_evt) state_d = GAME_RUN;
                GAME_RUN: begin
                    if (terminal && (time_q == TIME_LAST)) begin
                        state_d = GAME_END;
`ifdef SC_GAMETIMER_PAUSE_EN
                    end else if (pause_evt) begin
                        state_d = GAME_PAUSE;
`endif
                    end
                end
`ifdef SC_GAMETIMER_PAUSE_EN
                GAME_PAUSE: if (pause_evt) state_d = GAME_RUN;
`endif
                GAME_END: if (start_evt) state_d = GAME_IDLE;
                default: state_d = GAME_IDLE;
            endcase
        end
    end

    always_comb begin
        SC_GAMETIMER_STATE_OutBUS = state_q;
        SC_GAMETIMER_DONE_OutHigh = (state_q == GAME_END);
    end

    // Prescaler only moves in RUN, so a pause keeps the partial tick intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            time_q  <= '0;
            tick_q  <= 1'b0;
        end else if (SC_GAMETIMER_CLEAR_InHigh) begin
            presc_q <= '0;
            time_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            case (state_q)
                GAME_IDLE: begin
                    presc_q <= '0;
                    time_q  <= '0;
                    tick_q  <= 1'b0;
                end
                GAME_RUN: begin
                    if (terminal) begin
                        presc_q <= '0;
                        time_q  <= time_q + 1'b1;
                        tick_q  <= 1'b1;
                    end else begin
                        presc_q <= presc_q + 1'b1;
                        tick_q  <= 1'b0;
                    end
                end
                GAME_END: begin
                    tick_q <= 1'b0;
                    if (start_evt) time_q <= '0;
                end
                default: tick_q <= 1'b0;
            endcase
        end
    end

    assign SC_GAMETIMER_TIME_OutBUS  = time_q;
    assign SC_GAMETIMER_TICK_OutHigh = tick_q;

endmodule
